ahb_des_slave_regs: RTL and testbench

- Parametrised AHB-Lite slave register block fronting the Triple DES core.
- Decodes a 64-byte window at BASE_ADDR. Holds the data and key registers and a control/status pair, and launches the core with a one-cycle start pulse.
- Captures the core result.
- Inserts wait states on RESULT reads while the core is busy, with a timeout, and gives the full two-cycle ERROR response for illegal accesses.

---
 rtl/ahb_des_slave_regs.sv | 194 +++++++++++++++++++
 tb/tb_ahb_des_slave_regs.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ahb_des_slave_regs.sv
// AHB-Lite register front end for the Triple DES core: data/key/control registers,
// one-cycle start pulse, result capture, wait states on busy RESULT reads and ERROR responses.
module ahb_des_slave_regs #(
  parameter logic [31:0] BASE_ADDR = 32'hAAAA_AA00,
  parameter int          NUM_KEYS  = 3,
  parameter int          TIMEOUT   = 64,
  parameter logic        RESET_ENC = 1'b0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HREADY,
  input  logic [63:0] HWDATA,
  output logic [63:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  input  logic [63:0] output_data,
  input  logic        done,
  output logic        enable,
  output logic        encryption_type,
  output logic [63:0] data,
  output logic [63:0] key1,
  output logic [63:0] key2,
  output logic [63:0] key3,
  output logic [2:0]  fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DATA = 3'd1,
    S_WAIT = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  localparam logic [5:0] OFF_DATA   = 6'h00;
  localparam logic [5:0] OFF_KEY1   = 6'h08;
  localparam logic [5:0] OFF_KEY2   = 6'h10;
  localparam logic [5:0] OFF_KEY3   = 6'h18;
  localparam logic [5:0] OFF_CTRL   = 6'h20;
  localparam logic [5:0] OFF_STATUS = 6'h28;
  localparam logic [5:0] OFF_RESULT = 6'h30;
  localparam logic [5:0] OFF_HOLE   = 6'h38;
  localparam logic [7:0] TO_LAST    = 8'(TIMEOUT - 1);

  state_t      state, state_next, phase_next;
  logic [5:0]  off_q;
  logic        write_q;
  logic [7:0]  wait_cnt;
  logic        busy, done_flag, err_flag;
  logic [63:0] result;
  logic [63:0] rd_mux;

  logic [5:0]  off_a;
  logic        accept, addr_err, result_wait;
  logic        start_set, busy_next, status_w1c, data_wr;
  logic        unused_ok;

  assign unused_ok = HTRANS[0];
  assign fsm_state = state;
  assign off_a     = HADDR[5:0];

  // ERR2 completes the error response, so an address phase overlapping it is dropped.
  assign accept = HSEL & HREADY & HTRANS[1] & (HADDR[31:6] == BASE_ADDR[31:6])
                & (state != S_ERR2);

  assign data_wr    = (state == S_DATA) & write_q;
  assign start_set  = data_wr & (off_q == OFF_CTRL) & HWDATA[1] & ~busy;
  assign status_w1c = data_wr & (off_q == OFF_STATUS);
  assign busy_next  = start_set | (busy & ~done);

  // The access is judged against the busy value its data phase will see.
  assign addr_err = (HSIZE != 3'b011) | (off_a[2:0] != 3'b000) | (off_a == OFF_HOLE)
                  | (HWRITE & (off_a == OFF_RESULT))
                  | (HWRITE & (off_a < OFF_STATUS) & busy_next);
  assign result_wait = ~HWRITE & (off_a == OFF_RESULT) & busy_next;

  always_comb begin
    phase_next = S_IDLE;
    if (accept) begin
      if (addr_err)         phase_next = S_ERR1;
      else if (result_wait) phase_next = S_WAIT;
      else                  phase_next = S_DATA;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state   <= S_IDLE;
      off_q   <= 6'd0;
      write_q <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        off_q   <= off_a;
        write_q <= HWRITE;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: state_next = phase_next;
      S_DATA: state_next = phase_next;
      S_WAIT: begin
        if (done)                     state_next = phase_next;
        else if (wait_cnt == TO_LAST) state_next = S_ERR1;
        else                          state_next = S_WAIT;
      end
      S_ERR1: state_next = S_ERR2;
      S_ERR2: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    rd_mux = 64'd0;
    case (off_q)
      OFF_DATA:   rd_mux = data;
      OFF_KEY1:   rd_mux = key1;
      OFF_KEY2:   rd_mux = key2;
      OFF_KEY3:   rd_mux = key3;
      OFF_CTRL:   rd_mux = {63'd0, encryption_type};
      OFF_STATUS: rd_mux = {61'd0, err_flag, done_flag, busy};
      OFF_RESULT: rd_mux = result;
      default:    rd_mux = 64'd0;
    endcase
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = 64'd0;
    case (state)
      S_DATA: if (!write_q) HRDATA = rd_mux;
      S_WAIT: begin
        HREADYOUT = done;
        if (done) HRDATA = output_data;
      end
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      S_ERR2: HRESP = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) wait_cnt <= 8'd0;
    else if ((state == S_WAIT) && !done) wait_cnt <= wait_cnt + 8'd1;
    else wait_cnt <= 8'd0;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      data            <= 64'd0;
      key1            <= 64'd0;
      key2            <= 64'd0;
      key3            <= 64'd0;
      encryption_type <= RESET_ENC;
      enable          <= 1'b0;
      busy            <= 1'b0;
      done_flag       <= 1'b0;
      err_flag        <= 1'b0;
      result          <= 64'd0;
    end else begin
      enable <= start_set;
      busy   <= busy_next;
      if (data_wr) begin
        case (off_q)
          OFF_DATA: data <= HWDATA;
          OFF_KEY1: key1 <= HWDATA;
          OFF_KEY2: if (NUM_KEYS >= 2) key2 <= HWDATA;
          OFF_KEY3: if (NUM_KEYS >= 3) key3 <= HWDATA;
          OFF_CTRL: encryption_type <= HWDATA[0];
          default: ;
        endcase
      end
      // A completion in the same cycle as a W1C of done keeps done set.
      if (done && busy) done_flag <= 1'b1;
      else if (start_set || (status_w1c && HWDATA[1])) done_flag <= 1'b0;
      if (state == S_ERR1) err_flag <= 1'b1;
      else if (status_w1c && HWDATA[2]) err_flag <= 1'b0;
      if (done && busy) result <= output_data;
    end
  end

endmodule

// File: tb/tb_ahb_des_slave_regs.sv
// Directed bench for ahb_des_slave_regs: register access, start/done flow,
// RESULT wait states, timeout and error responses, reset during a wait.
module tb_ahb_des_slave_regs;

  localparam logic [31:0] BASE    = 32'hAAAA_AA00;
  localparam int          TIMEOUT = 64;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [63:0] HWDATA;
  logic [63:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [63:0] output_data;
  logic        done;
  logic        enable;
  logic        encryption_type;
  logic [63:0] data, key1, key2, key3;
  logic [2:0]  fsm_state;
  wire         HREADY = HREADYOUT;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] rdata;
  logic        resp;
  int          waits_ok;

  ahb_des_slave_regs #(
    .BASE_ADDR(BASE), .NUM_KEYS(3), .TIMEOUT(TIMEOUT), .RESET_ENC(1'b0)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HREADY(HREADY), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .output_data(output_data), .done(done), .enable(enable),
    .encryption_type(encryption_type), .data(data), .key1(key1), .key2(key2),
    .key3(key3), .fsm_state(fsm_state)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One transfer; optionally pulses done on data-phase cycle done_at (1-based).
  task automatic ahb(input logic wr, input logic [5:0] off, input logic [2:0] size,
                     input logic [63:0] wdata, input int done_at, input logic [63:0] core_val,
                     output logic [63:0] rd, output logic rsp, output int wok);
    bit finished = 0;
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = BASE | {26'd0, off}; HWRITE = wr; HSIZE = size;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wdata;
    wok = 0; rd = 64'd0; rsp = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      if (k == done_at) begin done = 1'b1; output_data = core_val; end
      else done = 1'b0;
      @(negedge HCLK);
      if (HREADYOUT) begin
        rd = HRDATA; rsp = HRESP; finished = 1;
        break;
      end
      if (!HRESP) wok++;
      @(posedge HCLK); #1;
    end
    if (!finished) check("bus_hang", {63'd0, HREADYOUT}, 64'd1);
    if (done) begin
      @(posedge HCLK); #1;
      done = 1'b0;
    end
  endtask

  task automatic write_ok(input string tag, input logic [5:0] off, input logic [63:0] val);
    ahb(1'b1, off, 3'b011, val, 0, 64'd0, rdata, resp, waits_ok);
    check({tag, "_resp"}, {63'd0, resp}, 64'd0);
  endtask

  task automatic write_err(input string tag, input logic [5:0] off, input logic [2:0] size);
    ahb(1'b1, off, size, 64'hDEAD_BEEF_DEAD_BEEF, 0, 64'd0, rdata, resp, waits_ok);
    check({tag, "_resp"}, {63'd0, resp}, 64'd1);
  endtask

  task automatic read_chk(input string tag, input logic [5:0] off, input logic [63:0] exp);
    ahb(1'b0, off, 3'b011, 64'd0, 0, 64'd0, rdata, resp, waits_ok);
    check(tag, rdata, exp);
    check({tag, "_resp"}, {63'd0, resp}, 64'd0);
  endtask

  task automatic pulse_done(input logic [63:0] val);
    @(posedge HCLK); #1;
    done = 1'b1; output_data = val;
    @(posedge HCLK); #1;
    done = 1'b0;
  endtask

  initial begin
    HRESET = 1'b1; HSEL = 1'b0; HADDR = 32'd0; HWRITE = 1'b0; HTRANS = 2'b00;
    HSIZE = 3'b011; HWDATA = 64'd0; output_data = 64'd0; done = 1'b0;
    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b0;
    @(negedge HCLK);
    check("rst_hreadyout", {63'd0, HREADYOUT}, 64'd1);
    check("rst_hresp", {63'd0, HRESP}, 64'd0);
    check("rst_hrdata", HRDATA, 64'd0);
    check("rst_enable", {63'd0, enable}, 64'd0);
    check("rst_enc", {63'd0, encryption_type}, 64'd0);
    check("rst_data", data, 64'd0);

    write_ok("wr_data", 6'h00, 64'h0123_4567_89AB_CDEF);
    @(negedge HCLK);
    check("data_out", data, 64'h0123_4567_89AB_CDEF);
    write_ok("wr_key1", 6'h08, 64'h1334_5779_9BBC_DFF1);
    write_ok("wr_key2", 6'h10, 64'h0E32_9232_EA6D_0D73);
    write_ok("wr_key3", 6'h18, 64'hA5A5_5A5A_0F0F_F0F0);
    @(negedge HCLK);
    check("key1_out", key1, 64'h1334_5779_9BBC_DFF1);
    check("key2_out", key2, 64'h0E32_9232_EA6D_0D73);
    check("key3_out", key3, 64'hA5A5_5A5A_0F0F_F0F0);
    read_chk("rd_key2", 6'h10, 64'h0E32_9232_EA6D_0D73);

    // Start with encrypt selected.
    write_ok("wr_ctrl3", 6'h20, 64'd3);
    @(negedge HCLK);
    check("enable_hi", {63'd0, enable}, 64'd1);
    check("enc_set", {63'd0, encryption_type}, 64'd1);
    @(negedge HCLK);
    check("enable_lo", {63'd0, enable}, 64'd0);
    read_chk("status_busy", 6'h28, 64'd1);
    read_chk("rd_ctrl", 6'h20, 64'd1);

    pulse_done(64'h85E8_1354_0F0A_B405);
    read_chk("status_done", 6'h28, 64'd2);
    read_chk("rd_result", 6'h30, 64'h85E8_1354_0F0A_B405);
    check("result_waits", waits_ok, 64'd0);

    // RESULT read while busy; completion on the sixth data-phase cycle.
    write_ok("wr_ctrl3b", 6'h20, 64'd3);
    ahb(1'b0, 6'h30, 3'b011, 64'd0, 6, 64'hFEDC_BA98_7654_3210, rdata, resp, waits_ok);
    check("wait_count", waits_ok, 64'd5);
    check("wait_rdata", rdata, 64'hFEDC_BA98_7654_3210);
    check("wait_resp", {63'd0, resp}, 64'd0);
    read_chk("status_after_wait", 6'h28, 64'd2);
    read_chk("result_after_wait", 6'h30, 64'hFEDC_BA98_7654_3210);

    // Start in decrypt mode, core never completes.
    write_ok("wr_ctrl2", 6'h20, 64'd2);
    @(negedge HCLK);
    check("enable_hi2", {63'd0, enable}, 64'd1);
    check("enc_clr", {63'd0, encryption_type}, 64'd0);
    ahb(1'b0, 6'h30, 3'b011, 64'd0, 0, 64'd0, rdata, resp, waits_ok);
    check("timeout_count", waits_ok, TIMEOUT);
    check("timeout_resp", {63'd0, resp}, 64'd1);
    read_chk("status_timeout", 6'h28, 64'd5);
    write_err("wr_data_busy", 6'h00, 3'b011);
    read_chk("data_kept_busy", 6'h00, 64'h0123_4567_89AB_CDEF);
    write_ok("w1c_err_busy", 6'h28, 64'd4);
    read_chk("status_err_clr", 6'h28, 64'd1);
    pulse_done(64'h1111_2222_3333_4444);
    read_chk("status_done2", 6'h28, 64'd2);

    // Illegal accesses while idle.
    write_err("bad_size", 6'h00, 3'b010);
    write_err("bad_align", 6'h04, 3'b011);
    write_err("wr_result", 6'h30, 3'b011);
    ahb(1'b0, 6'h38, 3'b011, 64'd0, 0, 64'd0, rdata, resp, waits_ok);
    check("rd_hole_resp", {63'd0, resp}, 64'd1);
    read_chk("data_kept", 6'h00, 64'h0123_4567_89AB_CDEF);
    read_chk("result_kept", 6'h30, 64'h1111_2222_3333_4444);
    read_chk("status_err", 6'h28, 64'd6);
    write_ok("w1c_err", 6'h28, 64'd4);
    read_chk("status_err_gone", 6'h28, 64'd2);
    write_ok("w1c_done", 6'h28, 64'd2);
    read_chk("status_clear", 6'h28, 64'd0);

    // Reset while a RESULT read is stalled.
    write_ok("wr_ctrl3c", 6'h20, 64'd3);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = BASE | 32'h30; HWRITE = 1'b0; HSIZE = 3'b011;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    @(negedge HCLK);
    check("stall_before_rst", {63'd0, HREADYOUT}, 64'd0);
    @(posedge HCLK); #1;
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    @(negedge HCLK);
    check("rst2_hreadyout", {63'd0, HREADYOUT}, 64'd1);
    check("rst2_hresp", {63'd0, HRESP}, 64'd0);
    check("rst2_data", data, 64'd0);
    check("rst2_key1", key1, 64'd0);
    check("rst2_key3", key3, 64'd0);
    check("rst2_enc", {63'd0, encryption_type}, 64'd0);
    read_chk("rst2_status", 6'h28, 64'd0);
    read_chk("rst2_result", 6'h30, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
